noise_gate: RTL and testbench
=============================

# noise_gate

Sample-domain noise gate placed directly upstream of the distortion stage. It tracks a smoothed envelope of the incoming guitar sample stream and applies a ramped gain (0.0 to 1.0) so that pickup hiss and hum are muted before the high-gain multiply-and-clamp amplifies them. Output samples keep the pipeline's 16-bit signed format and `bits_per_level` fixed-point gain scale.

## Interface
Parameters:
- `bits_per_level`, 12: fractional bits of the gain; unity = 2^bits_per_level (4096).
- `HOLD_SAMPLES`, 480: samples the gate stays fully open after the envelope drops below the close threshold.
- `ENV_SHIFT`, 6: envelope smoothing shift (one-pole coefficient 2^-ENV_SHIFT).
- `RAMP_STEP`, 64: gain change per accepted sample during attack and release.

Ports:
- `clk`, input, 1 bit: clock.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `in_valid`, input, 1 bit: `in_signal` carries a new sample this cycle.
- `in_signal`, input, 16 bit signed: input sample.
- `threshold`, input, 16 bit unsigned: open threshold on the envelope (0..32767 meaningful).
- `hysteresis`, input, 16 bit unsigned: open-to-close gap. Used only with the macro in Configuration.
- `out_valid`, output, 1 bit: `out_signal` is new this cycle.
- `out_signal`, output, 16 bit signed: gated sample.
- `gate_open`, output, 1 bit: high whenever the state is not CLOSED.

## Operation
All state advances only on cycles with `in_valid`=1. Idle cycles hold every register except `out_valid`.
- Magnitude: `mag = |in_signal|`. Input -32768 gives 32767.
- Envelope: `env` is 16 bit unsigned, range 0..32767. Update is `env_n = env + ((mag - env) >>> ENV_SHIFT)`, computed as a 17-bit signed difference with an arithmetic shift.
- Close threshold `close_thr` is `threshold` (see Configuration).
- Gain register `gain` is 0..2^bits_per_level. FSM decisions use `env_n`.
  - CLOSED: gain = 0. If `env_n >= threshold`, go to ATTACK.
  - ATTACK: gain = min(gain + RAMP_STEP, unity). When gain reaches unity, go to OPEN. If instead `env_n < close_thr`, go to RELEASE (no gain step that sample).
  - OPEN: gain = unity. If `env_n < close_thr`, go to HOLD and load `hold_cnt = HOLD_SAMPLES-1`.
  - HOLD: gain = unity. If `env_n >= threshold`, go to OPEN. Else if `hold_cnt == 0`, go to RELEASE. Else decrement `hold_cnt`.
  - RELEASE: gain = max(gain - RAMP_STEP, 0). When gain reaches 0, go to CLOSED. If `env_n >= threshold`, go to ATTACK (no gain step that sample).
- Output computation:
  - The output uses the gain held *before* this sample's update.
  - `prod = in_signal * gain` as a 32-bit signed value.
  - `out_signal = prod >>> bits_per_level`, truncated toward negative infinity. The result never exceeds 16 bits because gain ≤ unity.
- `threshold` and `hysteresis` are sampled on each valid cycle and may change at any time.
- `threshold = 0` opens the gate on the first valid sample.

## Timing
- Reset values: env=0, gain=0, hold_cnt=0, state=CLOSED, `out_signal`=0, `out_valid`=0, `gate_open`=0.
- Latency: 1 cycle. `out_valid` is high exactly one cycle after each `in_valid` cycle and low otherwise.
- Throughput: `in_valid` may be high every cycle. There is no back-pressure.
- `gate_open` is registered and reflects the state after the sample's update, aligned with `out_valid`.
- Reset asserted mid-ramp or in HOLD:
  - All registers take their reset values at the next edge.
  - Any output in flight is dropped, so `out_valid`=0 the cycle after reset.
  - An `in_valid` coinciding with `rst` is ignored.

## Configuration
- `NOISE_GATE_HYSTERESIS_EN` defined: `close_thr = threshold - hysteresis`, saturating at 0.
- Macro not defined: `close_thr = threshold`. The `hysteresis` port remains but is ignored.

## Test plan
- **Reset and unity ramp.** Reset, then `threshold`=0 with `in_signal`=1000 every cycle.
  - First `out_signal` is 0 and `gate_open`=1.
  - Outputs rise by 1000·64/4096 per sample (15, 31, …).
  - From the 65th output on, the output is exactly 1000.
- **Envelope and magnitude.** Constant 4096 gives env=64 after the first sample. A single −32768 sample from env=0 gives env=511. ENV_SHIFT=6 in both cases.
- **Hold then release.**
  - Setup: gate OPEN, `threshold`=2000, input switched to 0.
  - The output stays at 0 since the input is 0. `gate_open` stays 1 for HOLD_SAMPLES samples after env first drops below 2000.
  - The gate then releases over 64 samples and `gate_open` falls.
  - Probing with ±100 inputs shows the output scaling down as the gain ramps to 0.
- **Retrigger and back-to-back.**
  - Raise the input above threshold during RELEASE: the FSM goes to ATTACK with no gain step.
  - Drive `in_valid` continuously, then with 2-cycle gaps: outputs are identical in value, and `out_valid` mirrors `in_valid` delayed by 1.
- **Reset mid-ramp.** Assert `rst` at gain=2048 during ATTACK. Next cycle: `out_valid`=0, `gate_open`=0, and the next output is 0 for a non-zero input with `threshold`=30000.
- **Hysteresis.** `threshold`=2000, `hysteresis`=500, env settled at 1700.
  - With the macro: the gate stays OPEN.
  - Without the macro: the gate enters HOLD.

Source files
------------

// File: rtl/noise_gate.sv
// Noise gate: one-pole envelope follower driving a ramped-gain FSM.
// Define NOISE_GATE_HYSTERESIS_EN to close at (threshold - hysteresis) instead of threshold.
module noise_gate #(
  parameter int bits_per_level = 12,
  parameter int HOLD_SAMPLES   = 480,
  parameter int ENV_SHIFT      = 6,
  parameter int RAMP_STEP      = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] in_signal,
  input  logic        [15:0] threshold,
  input  logic        [15:0] hysteresis,
  output logic               out_valid,
  output logic signed [15:0] out_signal,
  output logic               gate_open
);

  localparam int GW = bits_per_level + 1;
  localparam int HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [GW-1:0] UNITY = GW'(2 ** bits_per_level);
  localparam logic [GW-1:0] STEP  = GW'(RAMP_STEP);

  typedef enum logic [2:0] {CLOSED, ATTACK, OPEN, HOLD, RELEASE} state_t;

  state_t               state, next_state;
  logic        [15:0]   env, env_n;
  logic        [GW-1:0] gain, gain_n, gain_up, gain_dn;
  logic        [HW-1:0] hold_cnt, hold_n;
  logic        [15:0]   mag, close_thr;
  logic signed [16:0]   diff, delta;
  logic signed [31:0]   prod;
  logic signed [15:0]   out_n;
  logic                 gate_open_n, open_hit, close_hit;

  // -32768 has no positive twin, so it saturates to 32767
  always_comb begin
    if (in_signal == 16'sh8000)
      mag = 16'h7fff;
    else if (in_signal[15])
      mag = 16'(-in_signal);
    else
      mag = 16'(in_signal);
  end

  assign diff  = $signed({1'b0, mag}) - $signed({1'b0, env});
  assign delta = diff >>> ENV_SHIFT;
  assign env_n = 16'($signed({1'b0, env}) + delta);

`ifdef NOISE_GATE_HYSTERESIS_EN
  assign close_thr = (threshold > hysteresis) ? (threshold - hysteresis) : 16'd0;
`else
  logic unused_hysteresis;
  assign unused_hysteresis = ^hysteresis;
  assign close_thr = threshold;
`endif

  assign open_hit  = (env_n >= threshold);
  assign close_hit = (env_n < close_thr);
  assign gain_up   = (gain >= UNITY - STEP) ? UNITY : gain + STEP;
  assign gain_dn   = (gain <= STEP) ? '0 : gain - STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLOSED;
      env        <= '0;
      gain       <= '0;
      hold_cnt   <= '0;
      out_signal <= '0;
      out_valid  <= 1'b0;
      gate_open  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        state      <= next_state;
        env        <= env_n;
        gain       <= gain_n;
        hold_cnt   <= hold_n;
        out_signal <= out_n;
        gate_open  <= gate_open_n;
      end
    end
  end

  // Opening from CLOSED takes the first ramp step on the triggering sample
  always_comb begin
    next_state = state;
    gain_n     = gain;
    hold_n     = hold_cnt;
    case (state)
      CLOSED: begin
        gain_n = '0;
        if (open_hit) begin
          gain_n     = gain_up;
          next_state = (gain_up == UNITY) ? OPEN : ATTACK;
        end
      end
      ATTACK: begin
        if (close_hit) begin
          next_state = RELEASE;
        end else begin
          gain_n = gain_up;
          if (gain_up == UNITY) next_state = OPEN;
        end
      end
      OPEN: begin
        gain_n = UNITY;
        if (close_hit) begin
          next_state = HOLD;
          hold_n     = HW'(HOLD_SAMPLES - 1);
        end
      end
      HOLD: begin
        gain_n = UNITY;
        if (open_hit)
          next_state = OPEN;
        else if (hold_cnt == '0)
          next_state = RELEASE;
        else
          hold_n = hold_cnt - 1'b1;
      end
      RELEASE: begin
        if (open_hit) begin
          next_state = ATTACK;
        end else begin
          gain_n = gain_dn;
          if (gain_dn == '0) next_state = CLOSED;
        end
      end
      default: begin
        next_state = CLOSED;
        gain_n     = '0;
      end
    endcase
  end

  // Output is scaled by the gain held before this sample's update
  always_comb begin
    gate_open_n = (next_state != CLOSED);
    prod        = $signed({{16{in_signal[15]}}, in_signal}) * $signed({{(32-GW){1'b0}}, gain});
    out_n       = 16'(prod >>> bits_per_level);
  end

endmodule

// File: tb/tb_noise_gate.sv
// Directed self-checking bench for noise_gate with hand-computed expectations.
module tb_noise_gate;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_signal;
  logic        [15:0] threshold;
  logic        [15:0] hysteresis;
  logic               out_valid;
  logic signed [15:0] out_signal;
  logic               gate_open;

  int total = 0;
  int bad   = 0;

  noise_gate dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_signal  (in_signal),
    .threshold  (threshold),
    .hysteresis (hysteresis),
    .out_valid  (out_valid),
    .out_signal (out_signal),
    .gate_open  (gate_open)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic signed [15:0] s);
    in_valid  = 1'b1;
    in_signal = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    hysteresis = 16'd0;
  endtask

  int ramp_exp [8] = '{0, 15, 31, 46, 62, 78, 93, 109};
  int retr_in  [6] = '{100, 100, 100, 32767, 100, 100};
  int retr_exp [6] = '{15, 15, 14, 4095, 12, 14};

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_signal  = '0;
    threshold  = '0;
    hysteresis = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_gate_open", int'(gate_open), 0);
    checkOutput("reset_out_signal", int'(out_signal), 0);
    rst = 1'b0;

    // unity ramp with threshold 0
    threshold = 16'd0;
    for (int n = 1; n <= 70; n++) begin
      int g;
      applyStimulus(16'sd1000);
      g = (n - 1) * 64;
      if (g > 4096) g = 4096;
      checkOutput("ramp_out", int'(out_signal), (1000 * g) / 4096);
      if (n == 1) begin
        checkOutput("ramp_first_gate", int'(gate_open), 1);
        checkOutput("ramp_first_valid", int'(out_valid), 1);
      end
    end
    idleCycle();
    checkOutput("idle_valid_low", int'(out_valid), 0);
    checkOutput("idle_out_hold", int'(out_signal), 1000);

    // envelope boundaries: 4096 -> 64, -32768 -> 511
    doReset(); threshold = 16'd64;
    applyStimulus(16'sd4096);
    checkOutput("env64_open", int'(gate_open), 1);
    checkOutput("env64_out", int'(out_signal), 0);
    doReset(); threshold = 16'd65;
    applyStimulus(16'sd4096);
    checkOutput("env64_closed", int'(gate_open), 0);
    doReset(); threshold = 16'd511;
    applyStimulus(-16'sd32768);
    checkOutput("env511_open", int'(gate_open), 1);
    doReset(); threshold = 16'd512;
    applyStimulus(-16'sd32768);
    checkOutput("env511_closed", int'(gate_open), 0);

    // hold then release with +-100 probing
    doReset(); threshold = 16'd0;
    for (int n = 0; n < 65; n++) applyStimulus(16'sd1000);
    threshold = 16'd2000;
    for (int k = 1; k <= 546; k++) begin
      int s;
      if (k <= 481) s = 0;
      else s = (((k - 482) % 2) == 0) ? 100 : -100;
      applyStimulus(16'(s));
      if (k == 1 || k == 481) begin
        checkOutput("hold_gate", int'(gate_open), 1);
        checkOutput("hold_out", int'(out_signal), 0);
      end
      if (k >= 482 && k <= 545) begin
        int g;
        int p;
        g = 4096 - 64 * (k - 482);
        p = s * g;
        checkOutput("release_out", int'(out_signal), p >>> 12);
      end
      if (k == 482) checkOutput("release_first", int'(out_signal), 100);
      if (k == 483) checkOutput("release_second", int'(out_signal), -99);
      if (k == 544) checkOutput("release_gate_last", int'(gate_open), 1);
      if (k == 545) checkOutput("release_gate_fall", int'(gate_open), 0);
      if (k == 546) checkOutput("closed_out", int'(out_signal), 0);
    end

    // attack -> release -> attack retrigger
    doReset(); threshold = 16'd0;
    for (int n = 0; n < 10; n++) applyStimulus(16'sd1000);
    threshold = 16'd300;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(16'(retr_in[i]));
      checkOutput("retrigger_out", int'(out_signal), retr_exp[i]);
      checkOutput("retrigger_gate", int'(gate_open), 1);
    end

    // gapped input: same values, out_valid follows in_valid by one cycle
    doReset(); threshold = 16'd0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(16'sd1000);
      checkOutput("gap_out", int'(out_signal), ramp_exp[i]);
      checkOutput("gap_valid_hi", int'(out_valid), 1);
      idleCycle();
      checkOutput("gap_valid_lo", int'(out_valid), 0);
      idleCycle();
    end

    // reset mid-ramp at gain 2048 with a coinciding in_valid
    doReset(); threshold = 16'd0;
    for (int n = 0; n < 32; n++) applyStimulus(16'sd1000);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_signal = 16'sd1000;
    @(posedge clk); #1;
    checkOutput("midrst_valid", int'(out_valid), 0);
    checkOutput("midrst_gate", int'(gate_open), 0);
    checkOutput("midrst_out", int'(out_signal), 0);
    rst       = 1'b0;
    threshold = 16'd30000;
    applyStimulus(16'sd1000);
    checkOutput("postrst_out", int'(out_signal), 0);
    checkOutput("postrst_gate", int'(gate_open), 0);
    checkOutput("postrst_valid", int'(out_valid), 1);

    // hysteresis with envelope settled near 1700
    doReset(); threshold = 16'd0;
    for (int n = 0; n < 400; n++) applyStimulus(16'sd1700);
    threshold  = 16'd2000;
    hysteresis = 16'd500;
    for (int n = 1; n <= 600; n++) begin
      applyStimulus(16'sd1700);
      if (n == 300) checkOutput("hyst_mid_gate", int'(gate_open), 1);
    end
`ifdef NOISE_GATE_HYSTERESIS_EN
    checkOutput("hyst_end_gate", int'(gate_open), 1);
    checkOutput("hyst_end_out", int'(out_signal), 1700);
`else
    checkOutput("hyst_end_gate", int'(gate_open), 0);
    checkOutput("hyst_end_out", int'(out_signal), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
